// File: rtl/cmd_sequencer.sv
// Drive-command queue: records operator instructions with append/undo-last, then
// replays them one per fixed-length step with pause, abort and optional looping.
module cmd_sequencer #(
    parameter  int CMD_W         = 4,
    parameter  int DEPTH         = 8,
    parameter  int STEP_CYCLES   = 50_000_000,
    parameter  int AUTO_RUN_FULL = 1,
    localparam int IW            = $clog2(DEPTH),
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK50,
    input  logic             rst_n,
    input  logic             save,
    input  logic             execute,
    input  logic             clear,
    input  logic             delete,
    input  logic             pause,
    input  logic             loop_mode,
    input  logic [CMD_W-1:0] cmd_in,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_valid,
    output logic [IW-1:0]    step_idx,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             done
);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOADED, RUN, PAUSED} state_t;

    state_t           state_q, state_d;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    step_q, step_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             done_d;
    logic             wr_en;
    logic             busy_d;
    logic             last_step;
    logic             timer_end;
    logic [CMD_W-1:0] cmd_out_q;
    logic             cmd_valid_q, empty_q, full_q, busy_q, done_q;

    assign last_step = (CW'(step_q) == count_q - CW'(1));
    assign timer_end = (timer_q == TW'(STEP_CYCLES - 1));
    assign busy_d    = (state_d == RUN) || (state_d == PAUSED);

    // Every RUN cycle advances the timer, including the one in which pause is
    // sampled; PAUSED cycles never do, so each entry gets exactly STEP_CYCLES.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        step_d  = step_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            step_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (save) begin
                        wr_en   = 1'b1;
                        count_d = CW'(1);
                        state_d = LOADED;
                    end
                end
                LOADED: begin
                    if (execute || ((AUTO_RUN_FULL != 0) && full_q)) begin
                        state_d = RUN;
                        step_d  = '0;
                        timer_d = '0;
                    end else if (save) begin
                        if (!full_q) begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end else if (delete) begin
                        count_d = count_q - CW'(1);
                        if (count_q == CW'(1)) state_d = IDLE;
                    end
                end
                RUN: begin
                    if (execute) begin
                        state_d = LOADED;
                        step_d  = '0;
                        timer_d = '0;
                    end else begin
                        if (pause) state_d = PAUSED;
                        if (!timer_end) begin
                            timer_d = timer_q + TW'(1);
                        end else begin
                            timer_d = '0;
                            if (!last_step) begin
                                step_d = step_q + IW'(1);
                            end else if (loop_mode) begin
                                step_d = '0;
                            end else begin
                                state_d = IDLE;
                                count_d = '0;
                                step_d  = '0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (execute) begin
                        state_d = LOADED;
                        step_d  = '0;
                        timer_d = '0;
                    end else if (pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            step_q      <= '0;
            timer_q     <= '0;
            cmd_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            step_q      <= step_d;
            timer_q     <= timer_d;
            cmd_out_q   <= busy_d ? mem_q[step_d] : '0;
            cmd_valid_q <= (state_d == RUN);
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == CW'(DEPTH));
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Writes only happen in IDLE/LOADED, so playback never reads a same-edge write.
    always_ff @(posedge CLOCK50) begin
        if (wr_en) mem_q[count_q[IW-1:0]] <= cmd_in;
    end

    assign cmd_out   = cmd_out_q;
    assign cmd_valid = cmd_valid_q;
    assign step_idx  = step_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
